// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/stop/target-count sequencer
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             inp,
  input  logic             inp_valid,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [PAT_W-1:0] r_pattern, r_hist, w_cand, w_mask;
  logic [PAT_W:0]   w_mask_full;
  logic [LEN_W-1:0] r_len, r_fill;
  logic             r_overlap, r_sat, r_cfg_err;
  logic [CNT_W-1:0] r_target, r_cnt, w_cnt_inc;
  logic             w_len_ok, w_hit, w_cfg_ok, w_enter_run, w_run_valid;
  assign w_cand      = {r_hist[PAT_W-2:0], inp};
  assign w_mask_full = ((PAT_W+1)'(1) << r_len) - (PAT_W+1)'(1);
  assign w_mask      = w_mask_full[PAT_W-1:0];
  assign w_len_ok    = r_fill >= (r_len - LEN_W'(1));
  assign w_run_valid = (r_state == S_RUN) & inp_valid;
  assign y           = w_run_valid & ~stop & w_len_ok & ((w_cand & w_mask) == (r_pattern & w_mask));
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_hit       = y & (r_target != '0) & (w_cnt_inc == r_target);
  assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign w_enter_run = (w_next == S_RUN) && (r_state != S_RUN);
  always_comb begin
    w_next = stop ? S_IDLE : (start && r_state != S_RUN) ? S_RUN : w_hit ? S_DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= PAT_W'(4'b1010);
      r_len     <= LEN_W'(4);
      r_overlap <= 1'b0;
      r_target  <= '0;
    end else if (cfg_we && r_state == S_IDLE && w_cfg_ok) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
    end
    r_cfg_err <= ~rst & cfg_we & ((r_state != S_IDLE) | ~w_cfg_ok);
  end
  // a non-overlapping match discards everything received so far
  always_ff @(posedge clk) begin
    if (rst || w_enter_run || (y && !r_overlap)) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_run_valid) begin
      r_hist <= w_cand;
      r_fill <= (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || w_enter_run) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (y) begin
      r_cnt <= (&r_cnt) ? r_cnt : w_cnt_inc;
      r_sat <= r_sat | (&w_cnt_inc);
    end
  end
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed table-driven checks of seq_detect_ctrl, plus a CNT_W=2 instance for saturation
module tb_seq_detect_ctrl;
  logic       clk, rst, cfg_we, cfg_overlap, start, stop, inp, inp_valid;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       y, busy, done, cnt_sat, cfg_err;
  logic [7:0] match_cnt;
  logic       y1, busy1, done1, cnt_sat1, cfg_err1;
  logic [1:0] match_cnt1;
  int n_cmp = 0, n_fail = 0;
  typedef struct packed {logic inp; logic vld; logic y;} vec_t;
  vec_t tv[3][11];
  seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .stop(stop),
    .inp(inp), .inp_valid(inp_valid), .y(y), .busy(busy), .done(done),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err));
  seq_detect_ctrl #(.PAT_W(8), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]), .start(start), .stop(stop),
    .inp(inp), .inp_valid(inp_valid), .y(y1), .busy(busy1), .done(done1),
    .match_cnt(match_cnt1), .cnt_sat(cnt_sat1), .cfg_err(cfg_err1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic apply(input logic b, input logic v, input logic e, input string nm);
    inp = b;
    inp_valid = v;
    #4;
    chk(nm, int'(y), int'(e));
    tick();
    inp_valid = 1'b0;
  endtask
  task automatic seq(input string nm, input int n, input logic [15:0] b, input logic [15:0] e);
    for (int i = 0; i < n; i++) apply(b[n-1-i], 1'b1, e[n-1-i], nm);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  task automatic run_tab(input int k, input string nm);
    for (int i = 0; i < 11; i++) apply(tv[k][i].inp, tv[k][i].vld, tv[k][i].y, nm);
  endtask
  initial begin
    logic [10:0] s, e_nov, e_ov, e_tg;
    s = 11'b10101011010; e_nov = 11'b00010000001; e_ov = 11'b00010100001; e_tg = 11'b00010100000;
    for (int i = 0; i < 11; i++) begin
      tv[0][i] = '{s[10-i], 1'b1, e_nov[10-i]};
      tv[1][i] = '{s[10-i], 1'b1, e_ov[10-i]};
      tv[2][i] = '{s[10-i], 1'b1, e_tg[10-i]};
    end
    rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
    start = 0; stop = 0; inp = 0; inp_valid = 0;
    tick(); tick();
    rst = 1'b0;
    #4;
    chk("rst_y", int'(y), 0); chk("rst_busy", int'(busy), 0); chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(match_cnt), 0); chk("rst_sat", int'(cnt_sat), 0); chk("rst_err", int'(cfg_err), 0);
    chk("rst_cnt1", int'(match_cnt1), 0);
    tick();
    // defaults, non-overlapping
    do_start();
    chk("t1_busy_start", int'(busy), 1);
    run_tab(0, "t1_y");
    chk("t1_cnt", int'(match_cnt), 2); chk("t1_busy", int'(busy), 1);
    // overlapping
    do_stop();
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    chk("t2_err", int'(cfg_err), 0);
    do_start();
    run_tab(1, "t2_y");
    chk("t2_cnt", int'(match_cnt), 3);
    // target 2 ends the run
    do_stop();
    cfg(8'b1010, 4'd4, 1'b1, 8'd2);
    do_start();
    run_tab(2, "t3_y");
    chk("t3_done", int'(done), 1); chk("t3_busy", int'(busy), 0); chk("t3_cnt", int'(match_cnt), 2);
    do_start();
    chk("t3_rerun_busy", int'(busy), 1); chk("t3_rerun_cnt", int'(match_cnt), 0); chk("t3_rerun_done", int'(done), 0);
    // config write during RUN is rejected
    cfg(8'b0000_0110, 4'd3, 1'b0, 8'd0);
    chk("t4_err_run", int'(cfg_err), 1);
    tick();
    chk("t4_err_once", int'(cfg_err), 0);
    seq("t4_y_run", 4, 16'b1010, 16'b0001);
    chk("t4_cnt_run", int'(match_cnt), 1);
    do_stop();
    cfg(8'b0000_0110, 4'd0, 1'b0, 8'd0);
    chk("t4_err_len0", int'(cfg_err), 1);
    do_start();
    seq("t4_y_len0", 6, 16'b101010, 16'b000101);
    chk("t4_done_len0", int'(done), 1);
    do_stop();
    cfg(8'b0000_0110, 4'd3, 1'b0, 8'd0);
    chk("t4_err_ok", int'(cfg_err), 0);
    do_start();
    seq("t4_y_len3", 3, 16'b110, 16'b001);
    // valid gaps with inp toggling
    do_stop();
    cfg(8'b1010, 4'd4, 1'b0, 8'd0);
    do_start();
    for (int k = 0; k < 4; k++) begin
      apply(k[0] ? 1'b0 : 1'b1, 1'b1, k == 3, "t5_y_valid");
      for (int g = 0; g < 3; g++) apply(g[0] ^ k[0], 1'b0, 1'b0, "t5_y_gap");
    end
    chk("t5_cnt", int'(match_cnt), 1);
    // saturation on the CNT_W=2 instance
    do_stop();
    cfg(8'h01, 4'd1, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b1, "t6_y_len1");
    chk("t6_cnt1", int'(match_cnt1), 3); chk("t6_sat1", int'(cnt_sat1), 1);
    chk("t6_cnt", int'(match_cnt), 5); chk("t6_sat", int'(cnt_sat), 0);
    // reset mid-run restores config defaults
    do_stop();
    cfg(8'b1010, 4'd4, 1'b1, 8'd3);
    do_start();
    seq("t6_y_pre_rst", 3, 16'b101, 16'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inp = 1'b0; inp_valid = 1'b1;
    #4;
    chk("t6r_y", int'(y), 0); chk("t6r_busy", int'(busy), 0); chk("t6r_done", int'(done), 0);
    chk("t6r_cnt", int'(match_cnt), 0); chk("t6r_err", int'(cfg_err), 0);
    tick();
    inp_valid = 1'b0;
    chk("t6r_cnt_after", int'(match_cnt), 0);
    do_start();
    seq("t6r_y_defaults", 6, 16'b101010, 16'b000100);
    chk("t6r_cnt_run", int'(match_cnt), 1); chk("t6r_busy_run", int'(busy), 1);
    // stop together with the last pattern bit
    do_stop();
    do_start();
    seq("t6s_y_pre", 3, 16'b101, 16'b000);
    stop = 1'b1;
    apply(1'b0, 1'b1, 1'b0, "t6s_y_stop");
    stop = 1'b0;
    chk("t6s_busy", int'(busy), 0); chk("t6s_done", int'(done), 0); chk("t6s_cnt", int'(match_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
